// File: rtl/ysyx_22050612_mem_arbiter.sv
// rtl/ysyx_22050612_mem_arbiter.sv - IFU/LSU arbiter for the single data-memory port (optional YSYX_22050612_MEM_ARB_RR_EN round-robin)
module ysyx_22050612_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic                ifu_resp_err,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic                lsu_resp_err,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;
    logic                  r_owner;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_sel_lsu;
    logic                  w_timeout;

    // Requester selection: the LSU wins unless round-robin hands a tie to the IFU.
    always_comb begin
        w_sel_lsu = 1'b0;
`ifdef YSYX_22050612_MEM_ARB_RR_EN
        w_sel_lsu = lsu_req_valid && (!ifu_req_valid || !r_owner);
`else
        w_sel_lsu = lsu_req_valid;
`endif
    end

    // Saturating WAIT counter increment and the timeout condition it feeds.
    always_comb begin
        w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
        w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus handshake and response outputs.
    always_comb begin
        w_state_next   = r_state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_err   = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_err   = 1'b0;
        lsu_rdata      = '0;
        case (r_state)
            S_IDLE: begin
                if (rst_n) begin
                    lsu_req_ready = w_sel_lsu;
                    ifu_req_ready = ifu_req_valid && !w_sel_lsu;
                    if (w_sel_lsu || ifu_req_valid) begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (r_owner) begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_err   = r_err;
                    lsu_rdata      = r_rdata;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_resp_err   = r_err;
                    ifu_rdata      = r_rdata;
                end
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request latch, WAIT counter, response capture and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_owner <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_ready) begin
                        r_we    <= lsu_we;
                        r_addr  <= lsu_addr;
                        r_wdata <= lsu_wdata;
                        r_wmask <= lsu_wmask;
                        r_owner <= 1'b1;
                    end else if (ifu_req_ready) begin
                        r_we    <= 1'b0;
                        r_addr  <= ifu_addr;
                        r_wdata <= '0;
                        r_wmask <= '0;
                        r_owner <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (mem_resp_valid) begin
                        r_rdata <= mem_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Sequences and shares the single data-memory port (the pmem_read/pmem_write DPI path) between two requesters: IFU (instruction fetch, read-only) and LSU (EXU load/store).
- One transaction in flight at a time.
- Valid/ready request handshake on every side; variable memory latency; response timeout.
- Sits between IFU/EXU and the memory wrapper.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width. Mask width is DATA_W/8.
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before an error response. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  one-cycle IFU response pulse.
- ifu_resp_err  out  1  IFU response is a timeout error.
- ifu_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte mask.
- lsu_resp_valid  out  1  one-cycle LSU response pulse (loads and stores).
- lsu_resp_err  out  1  LSU response is a timeout error.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepted the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory write mask.
- mem_resp_valid  in  1  memory response (read data, or write acknowledge).
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.
- owner  out  1  current or last grant; 0 = IFU, 1 = LSU.

Behaviour:
- Reset (rst_n = 0 at posedge): FSM to IDLE. All outputs 0, including owner, and all latched request registers cleared.
- Reset mid-transaction abandons the transaction. No response is issued. Late mem_resp_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - *_req_ready is combinational, high only for the selected requester and only in IDLE.
  - Selection is fixed priority: LSU over IFU.
  - On handshake, latch addr/we/wdata/wmask and owner; go to ISSUE. IFU requests latch we = 0 and mask = 0.
- ISSUE:
  - mem_req_valid = 1 with the latched fields held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
  - No timeout in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid: latch mem_rdata, err = 0, go to RESP.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC with no response: rdata = 0, err = 1, go to RESP.
  - If mem_resp_valid coincides with the timeout cycle, the response wins (err = 0).
- RESP:
  - The owner's resp_valid is high for exactly one cycle with registered rdata/err.
  - The other requester's resp outputs stay 0.
  - Go to IDLE. New requests are not accepted in RESP.
- Minimum latency:
  - Accept at cycle N, mem_req_valid at N+1 (ready same cycle), mem_resp_valid at N+2, resp_valid at N+3, next accept possible at N+4.
- Ignored inputs:
  - mem_resp_valid outside WAIT.
  - mem_req_ready outside ISSUE.
- Store responses: lsu_rdata carries whatever mem_rdata was sampled; the LSU ignores it.
- busy = (state != IDLE), registered.
- Counter width is clog2(TIMEOUT_CYC+1); it saturates and does not wrap.
- Requesters hold valid and fields until ready. Deassertion before ready is legal and simply cancels the request.

Optional Feature:
- Macro: YSYX_22050612_MEM_ARB_RR_EN.
- Defined: round-robin selection on simultaneous requests. The requester that is not the last owner wins, with owner after reset = 0 (IFU), so the first tie goes to LSU. A lone request is granted immediately regardless.
- Undefined: fixed LSU priority. IFU may starve under continuous LSU traffic.

Test Plan:
- Reset: rst_n = 0 for 2 cycles mid-WAIT, then mem_resp_valid = 1 -> no resp_valid; busy = 0, owner = 0, all mem_* = 0.
- IFU read: ifu addr 0x80000000, mem_req_ready = 1, mem_resp after 1 cycle with rdata 0x00000413_00000297 -> ifu_resp_valid one pulse at accept+3 with that data, err = 0.
- LSU store with backpressure: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xFF, mem_req_ready low 3 cycles -> mem fields stable all 4 ISSUE cycles; lsu_resp_valid one pulse after write acknowledge.
- Tie: both valid for 2 consecutive transactions:
  - Fixed priority -> LSU, LSU.
  - With RR_EN -> LSU, then IFU.
- Timeout: TIMEOUT_CYC = 4, no mem_resp -> lsu_resp_valid with err = 1, rdata = 0 exactly 5 cycles after entering WAIT (4 WAIT cycles, then RESP).
- Coincidence: mem_resp_valid on the same cycle the counter hits TIMEOUT_CYC -> err = 0 and data returned.
